// File: rtl/btn_reset_ctrl.sv
// btn_reset_ctrl
//   Conditions the raw user button: two-flop synchroniser, debounce, and a
//   press classifier. Short taps become a one-cycle short_press on release,
//   a hold of LONG_CYCLES raises a one-cycle long_press, and a hold of
//   REBOOT_CYCLES with reboot_en set pulls boot_rst_n low until reset.
//
// Ports
//   clk48       in   system clock (48 MHz)
//   rst_n       in   asynchronous active-low reset
//   usr_btn     in   raw button pin, asynchronous, 0 = pressed
//   reboot_en   in   arms the reboot request on a sustained hold
//   btn_pressed out  debounced level, 1 = pressed
//   short_press out  one-cycle pulse on release of a hold shorter than LONG_CYCLES
//   long_press  out  one-cycle pulse when the hold reaches LONG_CYCLES
//   boot_rst_n  out  active-low reboot request, sticky until rst_n
module btn_reset_ctrl #(
   parameter int DEBOUNCE_CYCLES = 480000,
   parameter int LONG_CYCLES     = 48000000,
   parameter int REBOOT_CYCLES   = 144000000
) (
   input  logic clk48,
   input  logic rst_n,
   input  logic usr_btn,
   input  logic reboot_en,
   output logic btn_pressed,
   output logic short_press,
   output logic long_press,
   output logic boot_rst_n
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(REBOOT_CYCLES + 1);

   localparam logic [DW-1:0] DEB_M1    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_M1   = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] REBOOT_M1 = HW'(REBOOT_CYCLES - 1);
   localparam logic [HW-1:0] REBOOT_SAT = HW'(REBOOT_CYCLES);

   typedef enum logic [1:0] {IDLE, HELD, LONG, REBOOT} state_t;

   logic          r_sync1, r_sync;
   logic [DW-1:0] r_deb_cnt;
   logic          r_btn;
   logic          w_cand;

   state_t        r_state, w_state_nxt;
   logic [HW-1:0] r_hold_cnt, w_hold_nxt;
   logic          r_short, w_short_nxt;
   logic          r_long, w_long_nxt;
   logic          r_boot_n, w_boot_nxt;

   // Synchroniser resets to the released level so a button held through
   // reset is re-debounced from scratch rather than seen instantly.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync  <= 1'b1;
      end else begin
         r_sync1 <= usr_btn;
         r_sync  <= r_sync1;
      end
   end

   assign w_cand = ~r_sync;

   // Counter runs only while the candidate level disagrees with the
   // accepted one; any agreement (a bounce back) restarts it.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_deb_cnt <= '0;
         r_btn     <= 1'b0;
      end else if (w_cand == r_btn) begin
         r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_M1) begin
         r_btn     <= w_cand;
         r_deb_cnt <= '0;
      end else begin
         r_deb_cnt <= r_deb_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_hold_cnt <= '0;
         r_short    <= 1'b0;
         r_long     <= 1'b0;
         r_boot_n   <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_short    <= w_short_nxt;
         r_long     <= w_long_nxt;
         r_boot_n   <= w_boot_nxt;
      end
   end

   // Pulses are registered on the transition edge, so each appears in the
   // first cycle of the destination state.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_short_nxt = 1'b0;
      w_long_nxt  = 1'b0;
      w_boot_nxt  = r_boot_n;
      case (r_state)
         IDLE: begin
            if (r_btn) begin
               w_state_nxt = HELD;
               w_hold_nxt  = '0;
            end
         end
         HELD: begin
            // Release is checked first: a release coinciding with the long
            // threshold still counts as a short press.
            if (!r_btn) begin
               w_state_nxt = IDLE;
               w_short_nxt = 1'b1;
               w_hold_nxt  = '0;
            end else if (r_hold_cnt == LONG_M1) begin
               w_state_nxt = LONG;
               w_long_nxt  = 1'b1;
               w_hold_nxt  = r_hold_cnt + 1'b1;
            end else begin
               w_hold_nxt  = r_hold_cnt + 1'b1;
            end
         end
         LONG: begin
            if (!r_btn) begin
               w_state_nxt = IDLE;
               w_hold_nxt  = '0;
            end else begin
               if (r_hold_cnt != REBOOT_SAT) w_hold_nxt = r_hold_cnt + 1'b1;
               // Saturation lets a late reboot_en still trigger.
               if (r_hold_cnt >= REBOOT_M1 && reboot_en) begin
                  w_state_nxt = REBOOT;
                  w_boot_nxt  = 1'b0;
               end
            end
         end
         REBOOT: begin
            // Only rst_n leaves this state.
            w_boot_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
         end
      endcase
   end

   assign btn_pressed = r_btn;
   assign short_press = r_short;
   assign long_press  = r_long;
   assign boot_rst_n  = r_boot_n;

endmodule
